// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// reorder_buffer_pkg: sizing constants and shared types for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int CNT_W     = IDX_W + 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic  write;
    reg_t  rd;
    data_t val;
    data_t pc;
  } commit_t;

endpackage
`default_nettype wire

// File: rtl/rob_bypass_cam.sv
`default_nettype none
// rob_bypass_cam: head-relative age scan over live entries; the youngest matching writer wins.
module rob_bypass_cam
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_DEPTH-1:0]             busy_i,
  input  logic [ROB_DEPTH-1:0]             done_i,
  input  logic [ROB_DEPTH-1:0]             write_i,
  input  logic [ROB_DEPTH-1:0][REG_W-1:0]  rd_i,
  input  logic [ROB_DEPTH-1:0][DATA_W-1:0] val_i,
  input  logic [IDX_W-1:0]                 head_i,
  input  logic [REG_W-1:0]                 lookup_reg_i,
  output logic                             hit_o,
  output logic                             ready_o,
  output logic [DATA_W-1:0]                val_o
);

  logic [IDX_W-1:0] slot;

  // Scanning oldest to youngest lets later matches overwrite earlier ones.
  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    val_o   = '0;
    slot    = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      slot = head_i + IDX_W'(i);
      if (busy_i[slot] && write_i[slot] && (rd_i[slot] == lookup_reg_i) && (lookup_reg_i != '0)) begin
        hit_o   = 1'b1;
        ready_o = done_i[slot];
        val_o   = val_i[slot];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// reorder_buffer: in-order retirement buffer; tags at fetch, fast/slow completion, one commit per cycle.
// Defining ROB_BYPASS_EN adds the lookup_reg/lookup_hit/lookup_ready/lookup_val forwarding port.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [DATA_W-1:0] alloc_pc,
  output logic              alloc_ok,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              fast_done,
  input  logic [IDX_W-1:0]  fast_idx,
  input  logic [REG_W-1:0]  fast_rd,
  input  logic [DATA_W-1:0] fast_val,
  input  logic              fast_write,
  input  logic              slow_done,
  input  logic [IDX_W-1:0]  slow_idx,
  input  logic [REG_W-1:0]  slow_rd,
  input  logic [DATA_W-1:0] slow_val,
  input  logic              slow_write,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_val,
  output logic              commit_write,
  output logic [DATA_W-1:0] commit_pc,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
`ifdef ROB_BYPASS_EN
  ,
  input  logic [REG_W-1:0]  lookup_reg,
  output logic              lookup_hit,
  output logic              lookup_ready,
  output logic [DATA_W-1:0] lookup_val
`endif
);

  logic [ROB_DEPTH-1:0]             busy_q, busy_d;
  logic [ROB_DEPTH-1:0]             done_q, done_d;
  logic [ROB_DEPTH-1:0]             write_q, write_d;
  logic [ROB_DEPTH-1:0][REG_W-1:0]  rd_q;
  logic [ROB_DEPTH-1:0][DATA_W-1:0] val_q;
  logic [ROB_DEPTH-1:0][DATA_W-1:0] pc_q;
  idx_t    head_q, head_d, tail_q, tail_d;
  cnt_t    count_q, count_d;
  logic    commit_valid_q, commit_valid_d;
  commit_t commit_q, commit_d;

  logic do_alloc, do_commit, fast_hit, slow_hit;

  assign full      = (count_q == cnt_t'(ROB_DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign alloc_ok  = alloc_req && !full && !flush;
  assign alloc_idx = tail_q;
  assign do_alloc  = alloc_ok;
  assign do_commit = busy_q[head_q] && done_q[head_q];
  assign fast_hit  = fast_done && busy_q[fast_idx];
  // Fast path owns the slot when both paths name the same tag.
  assign slow_hit  = slow_done && busy_q[slow_idx] && !(fast_done && (fast_idx == slow_idx));

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_q.rd;
  assign commit_val   = commit_q.val;
  assign commit_write = commit_q.write;
  assign commit_pc    = commit_q.pc;

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    write_d        = write_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_d       = commit_q;
    if (flush) begin
      busy_d   = '0;
      done_d   = '0;
      write_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      commit_d = '0;
    end else begin
      if (fast_hit) begin
        done_d[fast_idx]  = 1'b1;
        write_d[fast_idx] = fast_write;
      end
      if (slow_hit) begin
        done_d[slow_idx]  = 1'b1;
        write_d[slow_idx] = slow_write;
      end
      // Commit decision uses pre-edge done, so a same-cycle completion on head waits a cycle.
      if (do_commit) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
        commit_valid_d = 1'b1;
        commit_d       = '{write: write_q[head_q], rd: rd_q[head_q], val: val_q[head_q], pc: pc_q[head_q]};
      end
      if (do_alloc) begin
        busy_d[tail_q]  = 1'b1;
        done_d[tail_q]  = 1'b0;
        write_d[tail_q] = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + cnt_t'(do_alloc) - cnt_t'(do_commit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      write_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      write_q        <= write_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_q       <= commit_d;
    end
  end

  // Payload storage is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_alloc) pc_q[tail_q] <= alloc_pc;
    if (fast_hit) begin
      rd_q[fast_idx]  <= fast_rd;
      val_q[fast_idx] <= fast_val;
    end
    if (slow_hit) begin
      rd_q[slow_idx]  <= slow_rd;
      val_q[slow_idx] <= slow_val;
    end
  end

  fast_slow_same_idx: assert property (@(posedge clk) disable iff (!reset)
    !(fast_done && slow_done && (fast_idx == slow_idx)));

`ifdef ROB_BYPASS_EN
  rob_bypass_cam u_cam (
    .busy_i       (busy_q),
    .done_i       (done_q),
    .write_i      (write_q),
    .rd_i         (rd_q),
    .val_i        (val_q),
    .head_i       (head_q),
    .lookup_reg_i (lookup_reg),
    .hit_o        (lookup_hit),
    .ready_o      (lookup_ready),
    .val_o        (lookup_val)
  );
`endif

endmodule
`default_nettype wire
